// File: rtl/mac_pkg.sv
// Shared widths, operand/accumulator types and saturation limits for the MAC array.
// Default build wraps on overflow; MAC_SATURATE_EN switches mac_unit to clamping.
package mac_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ACC_W_DEF  = 32;

    typedef logic signed [DATA_W_DEF-1:0] data_t;
    typedef logic signed [ACC_W_DEF-1:0]  acc_t;

    localparam acc_t ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam acc_t ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

endpackage

// File: rtl/mac_mult.sv
// Combinational signed DATA_W x DATA_W -> 2*DATA_W multiplier; zero latency, no flow control.
// Kept separate so a DSP-mapped or pipelined multiplier can drop in unchanged.
module mac_mult
    import mac_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic signed [DATA_W-1:0]   a_i,
    input  logic signed [DATA_W-1:0]   b_i,
    output logic signed [2*DATA_W-1:0] p_o
);

    // Extending both operands first keeps the full product; it always fits in 2*DATA_W.
    assign p_o = (2*DATA_W)'(a_i) * (2*DATA_W)'(b_i);

endmodule

// File: rtl/mac_unit.sv
// Systolic MAC cell: o_result <= i_pre_result + i_data*i_weight, activation forwarded; 1-cycle latency.
// No backpressure: every o_valid beat must be taken. MAC_SATURATE_EN clamps overflow instead of wrapping.
module mac_unit
    import mac_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic signed [DATA_W-1:0] i_data,
    input  logic signed [DATA_W-1:0] i_weight,
    input  logic signed [ACC_W-1:0]  i_pre_result,
    output logic                     o_valid,
    output logic signed [DATA_W-1:0] o_data_next,
    output logic signed [ACC_W-1:0]  o_result
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    sum_sel;

    logic signed [ACC_W-1:0]  result_d, result_q;
    logic signed [DATA_W-1:0] data_d,   data_q;
    logic                     valid_d,  valid_q;

    mac_mult #(
        .DATA_W (DATA_W)
    ) u_mult (
        .a_i (i_data),
        .b_i (i_weight),
        .p_o (prod)
    );

`ifdef MAC_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // One guard bit: the true sign sits in bit ACC_W, disagreement with bit ACC_W-1 means overflow.
    logic signed [ACC_W:0] sum_wide;
    assign sum_wide = (ACC_W+1)'(i_pre_result) + (ACC_W+1)'(prod);

    always_comb begin
        sum_sel = sum_wide[ACC_W-1:0];
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
            sum_sel = sum_wide[ACC_W] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign sum_sel = i_pre_result + ACC_W'(prod);
`endif

    // Result and activation hold on idle cycles; only the valid flag drops.
    always_comb begin
        result_d = result_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        if (i_valid) begin
            result_d = sum_sel;
            data_d   = i_data;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            result_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_data_next = data_q;
    assign o_result    = result_q;

endmodule

// File: tb/tb_mac_unit.sv
// Self-checking bench for mac_unit: directed literal cases plus randomized stream vs. an arithmetic model.
// Honours MAC_SATURATE_EN the same way the design does.
module tb_mac_unit;

    logic               i_clk;
    logic               i_rst;
    logic               i_valid;
    logic signed [15:0] i_data;
    logic signed [15:0] i_weight;
    logic signed [31:0] i_pre_result;
    logic               o_valid;
    logic signed [15:0] o_data_next;
    logic signed [31:0] o_result;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: what the outputs must show after the most recent edge.
    bit          armed = 0;
    logic        m_valid;
    logic [15:0] m_data;
    logic [31:0] m_result;

    mac_unit #(.DATA_W(16), .ACC_W(32)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .i_weight     (i_weight),
        .i_pre_result (i_pre_result),
        .o_valid      (o_valid),
        .o_data_next  (o_data_next),
        .o_result     (o_result)
    );

    initial begin
        i_clk = 0;
        forever #5 i_clk = ~i_clk;
    end

    function automatic logic [31:0] model_sum(input longint d, input longint w, input longint p);
        longint s;
        s = p + d * w;
`ifdef MAC_SATURATE_EN
        if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
        return s[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge i_clk) begin
        if (i_rst) begin
            armed    = 1;
            m_valid  = 0;
            m_data   = '0;
            m_result = '0;
        end else if (armed) begin
            if (i_valid) begin
                m_valid  = 1;
                m_data   = i_data;
                m_result = model_sum(longint'(i_data), longint'(i_weight), longint'(i_pre_result));
            end else begin
                m_valid = 0;
            end
        end
    end

    always @(negedge i_clk) begin
        if (armed) begin
            chk("model_valid",  {31'd0, o_valid}, {31'd0, m_valid});
            chk("model_data",   {16'd0, o_data_next}, {16'd0, m_data});
            chk("model_result", o_result, m_result);
        end
    end

    task automatic step(input logic rst, input logic v, input int d, input int w, input int p);
        i_rst        = rst;
        i_valid      = v;
        i_data       = d[15:0];
        i_weight     = w[15:0];
        i_pre_result = p;
        @(posedge i_clk);
        #1;
    endtask

    function automatic int rand_data();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return -32768;
        if (r == 1) return 32767;
        if (r == 2) return -1;
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    function automatic int rand_acc();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return 32'h7FFF_FFF0 + int'($urandom_range(0, 15));
        if (r == 1) return 32'h8000_0000 + int'($urandom_range(0, 15));
        return int'($urandom);
    endfunction

    initial begin
        logic [31:0] ov_pos, ov_neg;
`ifdef MAC_SATURATE_EN
        ov_pos = 32'h7FFF_FFFF;
        ov_neg = 32'h8000_0000;
`else
        ov_pos = 32'h8000_0000;
        ov_neg = 32'h7FFF_FFFF;
`endif
        // Pin the model to hand-computed values.
        chk("model_pin_basic",  model_sum(1, 2, 3), 32'd5);
        chk("model_pin_signed", model_sum(-3, 5, 10), -32'sd5);
        chk("model_pin_min",    model_sum(-32768, -32768, 0), 32'd1073741824);
        chk("model_pin_ovf",    model_sum(1, 1, 32'h7FFF_FFFF), ov_pos);

        // Reset with random operands and valid asserted.
        step(1, 1, rand_data(), rand_data(), rand_acc());
        chk("rst_valid",  {31'd0, o_valid}, 32'd0);
        chk("rst_data",   {16'd0, o_data_next}, 32'd0);
        chk("rst_result", o_result, 32'd0);

        step(0, 1, 1, 2, 3);
        chk("b2b1_result", o_result, 32'd5);
        chk("b2b1_data",   {16'd0, o_data_next}, 32'd1);
        chk("b2b1_valid",  {31'd0, o_valid}, 32'd1);
        step(0, 1, 1, 4, 3);
        chk("b2b2_result", o_result, 32'd7);
        chk("b2b2_data",   {16'd0, o_data_next}, 32'd1);
        step(0, 1, 4, 2, 6);
        chk("b2b3_result", o_result, 32'd14);
        chk("b2b3_data",   {16'd0, o_data_next}, 32'd4);

        step(0, 1, -3, 5, 10);
        chk("signed_result", o_result, -32'sd5);
        step(0, 1, -32768, -32768, 0);
        chk("minmin_result", o_result, 32'd1073741824);

        step(0, 1, 2, 3, 1);
        chk("pre_hold_result", o_result, 32'd7);
        step(0, 0, 9, 9, 9);
        chk("hold_result", o_result, 32'd7);
        chk("hold_data",   {16'd0, o_data_next}, 32'd2);
        chk("hold_valid",  {31'd0, o_valid}, 32'd0);

        step(0, 1, 1, 1, 32'h7FFF_FFFF);
        chk("ovf_pos", o_result, ov_pos);
        step(0, 1, -1, 1, 32'h8000_0000);
        chk("ovf_neg", o_result, ov_neg);

        step(1, 1, 5, 5, 5);
        chk("midrst_result", o_result, 32'd0);
        chk("midrst_valid",  {31'd0, o_valid}, 32'd0);
        step(0, 1, 2, 2, 0);
        chk("post_rst_result", o_result, 32'd4);
        chk("post_rst_valid",  {31'd0, o_valid}, 32'd1);

        // Randomized stream; the negedge compare process checks every cycle.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 70),
                 rand_data(), rand_data(), rand_acc());
        end
        step(0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_unit.md
# mac_unit

Signed multiply-accumulate processing element for the systolic-array datapath. Each cycle it multiplies an activation by a weight, adds the partial sum from the upstream element, and registers the sum for the downstream element. It also registers the activation so it can pass to the neighbouring element. One instance sits at every array cell.

## Interface
- DATA_W, default 16: activation and weight width, two's-complement signed.
- ACC_W, default 32: partial-sum width, two's-complement signed; must satisfy ACC_W ≥ 2·DATA_W.
- i_clk  in  1  rising-edge clock.
- i_rst  in  1  reset; one clock, synchronous, active-high.
- i_valid  in  1  the input operands are valid this cycle.
- i_data  in  DATA_W  activation.
- i_weight  in  DATA_W  weight.
- i_pre_result  in  ACC_W  upstream partial sum.
- o_valid  out  1  o_result and o_data_next are valid.
- o_data_next  out  DATA_W  registered activation, forwarded to the neighbour.
- o_result  out  ACC_W  registered i_pre_result + i_data·i_weight.

## Operation
- Product: full-precision signed DATA_W×DATA_W product, 2·DATA_W bits, sign-extended to ACC_W.
- Sum: i_pre_result + sign-extended product, evaluated at ACC_W width.
- Without saturation, overflow wraps modulo 2^ACC_W.
- On a rising edge with i_valid=1:
  - o_result ← sum
  - o_data_next ← i_data
  - o_valid ← 1
- On a rising edge with i_valid=0:
  - o_result and o_data_next hold their values.
  - o_valid ← 0.
- The block has no internal accumulator state. Chaining happens through i_pre_result.
- Combinational path runs from the inputs to the register D inputs only. Outputs come straight from registers.

## Timing
- Latency is 1 cycle: operands sampled at edge N appear on the outputs after edge N. Throughput is one operation per cycle.
- Reset, sampled at an edge with i_rst=1: o_result=0, o_data_next=0, o_valid=0.
- Reset takes priority over i_valid.
- Reset asserted mid-stream discards the in-flight result. The first valid input after reset is released produces output one cycle later.
- There is no backpressure. Downstream must accept every o_valid beat.

## Configuration
- MAC_SATURATE_EN defined: an ACC_W-bit signed overflow in the sum clamps o_result.
  - Positive overflow → 2^(ACC_W-1)−1.
  - Negative overflow → −2^(ACC_W-1).
  - Overflow is detected by comparing the sign of the (ACC_W+1)-bit sum against bit ACC_W-1.
- MAC_SATURATE_EN undefined: modulo-2^ACC_W wrap, with no extra logic.
- No other behaviour changes with the macro.

## Structure
- Shared package mac_pkg holds:
  - default widths DATA_W_DEF=16 and ACC_W_DEF=32;
  - typedefs data_t (signed DATA_W) and acc_t (signed ACC_W);
  - saturation limit constants ACC_MAX and ACC_MIN.
- One sub-module, mac_mult: a combinational signed multiplier, DATA_W×DATA_W → 2·DATA_W. It is isolated so a DSP-mapped or pipelined variant can be substituted.
- Adder, saturation and output registers live in mac_unit.

## Test plan
- Reset: assert i_rst for 1 cycle with random inputs driven → all outputs 0 and o_valid=0 after the edge.
- Back-to-back stream with i_valid=1:
  - (1,2,3) → o_result=5, o_data_next=1
  - (1,4,3) → 7, 1
  - (4,2,6) → 14, 4
  - each appears one cycle after its operands.
- Signed operands: (−3,5,10) → o_result=−5. Then (−32768,−32768,0) → 1073741824.
- Hold: i_valid=0 after (2,3,1) → o_result stays 7, o_data_next stays 2, o_valid=0.
- Overflow: i_pre_result=0x7FFFFFFF, (1,1):
  - without the macro → 0x80000000;
  - with MAC_SATURATE_EN → 0x7FFFFFFF.
  - Mirror case at 0x80000000 with (−1,1).
- Reset mid-stream: i_rst=1 together with i_valid=1 and (5,5,5) → outputs 0; the next valid beat (2,2,0) → 4 one cycle later.
